// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: one outstanding PC-addressed fetch, read from a word ROM
// after a fixed LATENCY, returned over a valid/ready handshake; flush drops the access.
module instr_mem_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned LATENCY    = 2,
  // Program image; elaboration-time contents stand in for a hex file load
  parameter logic [DATA_WIDTH-1:0] ROM_INIT [MEM_DEPTH] = '{default: '0}
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_instr_o,
  output logic                  resp_err_o
);

  // state  | meaning
  // IDLE   | no access outstanding, ready for a request
  // WAIT   | access accepted, latency counter running
  // RESP   | response presented, waiting for resp_ready
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    capture;
  logic [DATA_WIDTH-1:0]   cap_addr;
  logic [IDX_W-1:0]        cap_idx;
  logic                    cap_fault;

  // With single-cycle latency the ROM is read on the accept edge itself
  assign cap_addr  = (LATENCY == 1) ? req_addr_i : addr_q;
  assign cap_idx   = cap_addr[IDX_W+1:2];
  assign cap_fault = (|cap_addr[1:0]) |
                     ({2'b00, cap_addr[DATA_WIDTH-1:2]} >= DATA_WIDTH'(MEM_DEPTH));
  assign accept    = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    capture = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (state_q == S_RESP && resp_ready_i) state_d = S_IDLE;
          if (accept) begin
            addr_d = req_addr_i;
            if (LATENCY == 1) begin
              state_d = S_RESP;
              capture = 1'b1;
            end else begin
              state_d = S_WAIT;
              cnt_d   = 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = S_RESP;
            cnt_d   = '0;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Faulting addresses never index the ROM; they return a NOP with the error flag
  always_comb begin
    instr_d = instr_q;
    err_d   = err_q;
    if (capture) begin
      err_d   = cap_fault;
      instr_d = cap_fault ? NOP_INSTR : ROM_INIT[cap_idx];
    end
  end

  always_comb begin
    resp_valid_o = (state_q == S_RESP);
    resp_instr_o = instr_q;
    resp_err_o   = err_q;
    req_ready_o  = rst_ni & ~flush_i &
                   ((state_q == S_IDLE) | ((state_q == S_RESP) & resp_ready_i));
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder at LATENCY=2, MEM_DEPTH=1024.
module tb_instr_mem_responder;

  localparam logic [31:0] PROG [1024] = '{
    0: 32'h00500093, 1: 32'h00a00113, 2: 32'h00f00193, 3: 32'h01400213,
    1023: 32'hdeadbeef, default: 32'h00000000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  instr_mem_responder #(
    .DATA_WIDTH(32), .MEM_DEPTH(1024), .LATENCY(2), .ROM_INIT(PROG)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_instr_o(resp_instr), .resp_err_o(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept at edge T, expect response visible after edge T+1, consume at T+2
  task automatic fetch(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_instr, input logic exp_err);
    req_valid = 1'b1; req_addr = addr; #1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk); req_valid = 1'b0;
    chk({tag, "_valid_early"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_instr"}, resp_instr, exp_instr);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    chk({tag, "_valid_after"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b0;
    // reset
    repeat (3) @(negedge clk);
    chk("rst_req_ready_forced", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(resp_valid), 32'd0);
    chk("post_rst_instr", resp_instr, 32'h0);
    chk("post_rst_err", 32'(resp_err), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // single fetches and faults
    fetch("rom0", 32'h0, 32'h00500093, 1'b0);
    fetch("misalign", 32'h6, 32'h00000013, 1'b1);
    fetch("oor", 32'h1000, 32'h00000013, 1'b1);
    fetch("last_word", 32'hffc, 32'hdeadbeef, 1'b0);
    fetch("misalign_lsb", 32'h3, 32'h00000013, 1'b1);

    // backpressure
    req_valid = 1'b1; req_addr = 32'h4;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_instr", resp_instr, 32'h00a00113);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    chk("bp_done_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("bp_no_dup", 32'(resp_valid), 32'd0);

    // flush during WAIT
    req_valid = 1'b1; req_addr = 32'h8;
    @(negedge clk); req_valid = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_wait_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    // flush together with a request: nothing accepted
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10; #1;
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk); flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("flush_no_accept2", 32'(resp_valid), 32'd0);
    fetch("after_flush", 32'hc, 32'h01400213, 1'b0);

    // flush in RESP beats resp_ready and req_valid
    req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("flush_resp_pre", 32'(resp_valid), 32'd1);
    flush = 1'b1; resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    @(negedge clk); flush = 1'b0; resp_ready = 1'b0; req_valid = 1'b0; #1;
    chk("flush_resp_drop", 32'(resp_valid), 32'd0);
    chk("flush_resp_idle", 32'(req_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    chk("flush_resp_no_accept", 32'(resp_valid), 32'd0);

    // back-to-back, one response every 2 cycles
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_gap", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("b2b_valid", 32'(resp_valid), 32'd1);
      chk("b2b_instr", resp_instr, PROG[i]);
      chk("b2b_req_ready", 32'(req_ready), 32'd1);
      if (i < 2) req_addr = 32'((i + 1) * 4);
      else req_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b_no_dup", 32'(resp_valid), 32'd0);
    resp_ready = 1'b0;

    // reset mid-WAIT
    req_valid = 1'b1; req_addr = 32'h4;
    @(negedge clk); req_valid = 1'b0; rst_n = 1'b0; #1;
    chk("rst_wait_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_wait_no_resp", 32'(resp_valid), 32'd0);
    end

    // reset mid-RESP drops valid asynchronously
    req_valid = 1'b1; req_addr = 32'h8;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("rst_resp_pre", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("rst_resp_async_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_async_instr", resp_instr, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_resp_no_resp", 32'(resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
